toggle_activity_monitor: RTL and testbench
==========================================

# toggle_activity_monitor

Observes a WIDTH-bit signal bus, such as the `count` output of `counter`, and measures its switching activity over fixed windows of WINDOW bus transitions. It is the consuming end of the activity path: a block under test drives the bus, and this monitor reduces the bus to per-window toggle totals for the power-estimation datapath. Results leave through a single-entry valid/ready output register.

## Interface
Parameters:
- WIDTH, 4, width of the observed bus.
- WINDOW, 16, number of consecutive-cycle comparisons per window; ≥1.
- TOG_W, $clog2(WIDTH*WINDOW+1), width of the window toggle total.
- BIT_W, $clog2(WINDOW+1), width of each per-bit toggle counter.
- IDX_W, max(1,$clog2(WIDTH)), width of the bit-index output.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  monitoring enable.
- sample_in  in  WIDTH  observed bus; sampled every cycle.
- res_valid  out  1  a result is held.
- res_ready  in  1  consumer accepts the result.
- res_toggles  out  TOG_W  total bit toggles in the window.
- res_max_bit  out  IDX_W  index of the most-toggling bit; the lowest index wins ties.
- res_max_cnt  out  BIT_W  toggle count of that bit.
- overrun  out  1  sticky; a completed window was dropped.

## Operation
- FSM states: IDLE, PRIME, ACCUM.
  - IDLE: counters are cleared. Go to PRIME when en=1.
  - PRIME: capture sample_in into prev; go to ACCUM. If en=0, go to IDLE.
  - ACCUM: each cycle with en=1:
    - diff = sample_in ^ prev.
    - acc += popcount(diff).
    - bitcnt[i] += diff[i].
    - prev <= sample_in.
    - ncmp++.
  - Window close: on the comparison that makes ncmp==WINDOW, form the result from the values that include this comparison. Then clear acc, bitcnt and ncmp, and stay in ACCUM. prev carries over, so there is no re-prime and no transition is lost between windows.
- en=0 in PRIME or ACCUM: go to IDLE; the partial window is discarded. A held result is unaffected.
- Max-bit selection: strict greater-than scan from bit 0 upward, so the lowest index wins ties.
- Widths: acc cannot overflow, since TOG_W covers WIDTH*WINDOW. Per-bit counters are bounded by WINDOW.
- Output register:
  - A completed window loads res_* and sets res_valid when res_valid=0, or when res_valid=1 and res_ready=1 in the same cycle.
  - Otherwise the new result is dropped, the held result is preserved, and overrun is set.
  - A handshake (res_valid & res_ready) with no simultaneous completion clears res_valid. res_* keep their last value.
- overrun clears only on rst.
- Reset values: FSM=IDLE, res_valid=0, res_toggles=0, res_max_bit=0, res_max_cnt=0, overrun=0, and all internal counters and prev = 0.
- rst mid-window or with a result pending: everything returns to reset values and the pending result is lost.

## Timing
- First cycle with en=1 (IDLE): no capture.
- Next cycle (PRIME): prev captured.
- ACCUM cycle k (k=1..WINDOW): one comparison.
- res_valid rises in the cycle after the edge that took comparison WINDOW.
  - Latency from that edge is 1 cycle.
  - From the first en=1 cycle it is WINDOW+2 cycles.
- Steady state: one result every WINDOW cycles.
- res_* are registered outputs with no combinational path from sample_in.
- res_ready is never registered; it acts in its own cycle.
- Outputs are stable while res_valid=1 and res_ready=0.

## Structure
- Shared package power_est_pkg holds:
  - the FSM state enum (IDLE, PRIME, ACCUM);
  - the width-derivation function used for TOG_W, BIT_W and IDX_W.
- Sub-module popcount (parameter WIDTH, combinational Hamming weight of diff): reused by later activity and power blocks.
- The max-bit scan stays inline.

## Test plan
- 4-bit `counter` drives sample_in (0,1,…,15,0), WINDOW=16, res_ready=1 → res_toggles=30 (bit0:16, bit1:8, bit2:4, bit3:2), res_max_bit=0, res_max_cnt=16. Second window identical, with no gap in the transition stream.
- Constant sample_in=4'hA for 2 windows → two results of res_toggles=0, res_max_bit=0, res_max_cnt=0.
- Alternating 4'h0/4'hF, WINDOW=16 → res_toggles=64; all bits tie at 16, so res_max_bit=0.
- Counter stimulus with res_ready=0 for 3 windows:
  - res_valid holds the first result, 30;
  - overrun=1 after window 2;
  - raising res_ready in the same cycle as a window close loads the new result with no gap.
- en dropped at comparison 7, then re-raised → PRIME repeats; the next result covers only the new WINDOW comparisons.
- rst asserted mid-window with a result pending → next cycle: res_valid=0, overrun=0, state IDLE, all res_* = 0.

Source files
------------

// File: rtl/power_est_pkg.sv
// power_est_pkg
// Shared definitions for the activity / power-estimation path.
//   state_t   : monitor FSM states (IDLE, PRIME, ACCUM)
//   width_for : bits needed to hold values 0..n-1, never less than 1
package power_est_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_ACCUM = 2'd2
    } state_t;

    function automatic int width_for(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/popcount.sv
// popcount
// Combinational Hamming weight of a bit vector.
//   i_bits  [WIDTH-1:0] : vector to count
//   o_count [CNT_W-1:0] : number of ones in i_bits
module popcount #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic [WIDTH-1:0] i_bits,
    output logic [CNT_W-1:0] o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_count = o_count + CNT_W'(i_bits[i]);
        end
    end

endmodule

// File: rtl/toggle_activity_monitor.sv
// toggle_activity_monitor
// Measures switching activity of a WIDTH-bit bus over windows of WINDOW
// consecutive-cycle comparisons and hands out per-window results.
//   clk, rst     : clock, synchronous active-high reset
//   en           : monitoring enable; dropping it discards the partial window
//   sample_in    : observed bus, sampled every cycle
//   res_valid    : a result is held in the output register
//   res_ready    : consumer accepts the held result this cycle
//   res_toggles  : total bit toggles in the window
//   res_max_bit  : most-toggling bit index (lowest index wins ties)
//   res_max_cnt  : toggle count of res_max_bit
//   overrun      : sticky, a completed window was dropped
//   dbg_state    : current FSM state (state_t encoding)
//
// Handshake: a result transfers on any cycle where res_valid and res_ready
// are both 1. res_valid only drops after a transfer; res_* are stable while
// res_valid=1 and res_ready=0. res_ready is used combinationally in its own
// cycle, so a window closing in a transfer cycle replaces the result with no
// gap. A window closing while a result is held and not accepted is dropped
// and sets overrun.
module toggle_activity_monitor
    import power_est_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int WINDOW = 16,
    parameter int TOG_W  = width_for(WIDTH * WINDOW + 1),
    parameter int BIT_W  = width_for(WINDOW + 1),
    parameter int IDX_W  = width_for(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] sample_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [TOG_W-1:0] res_toggles,
    output logic [IDX_W-1:0] res_max_bit,
    output logic [BIT_W-1:0] res_max_cnt,
    output logic             overrun,
    output logic [1:0]       dbg_state
);

    localparam int POP_W = width_for(WIDTH + 1);

    // ---------------- FSM ----------------
    state_t r_state;
    state_t w_next_state;
    logic   w_clear;
    logic   w_capture;
    logic   w_compare;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  w_next_state = en ? ST_PRIME : ST_IDLE;
            ST_PRIME: w_next_state = en ? ST_ACCUM : ST_IDLE;
            ST_ACCUM: w_next_state = en ? ST_ACCUM : ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_clear   = (r_state == ST_IDLE);
        w_capture = (r_state == ST_PRIME);
        w_compare = (r_state == ST_ACCUM) && en;
    end

    assign dbg_state = r_state;

    // ---------------- Datapath ----------------
    logic [WIDTH-1:0] r_prev;
    logic [TOG_W-1:0] r_acc;
    logic [BIT_W-1:0] r_ncmp;
    logic [BIT_W-1:0] r_bitcnt      [WIDTH];
    logic [BIT_W-1:0] w_bitcnt_next [WIDTH];
    logic [WIDTH-1:0] w_diff;
    logic [POP_W-1:0] w_pop;
    logic [TOG_W-1:0] w_acc_next;
    logic             w_window_done;
    logic [IDX_W-1:0] w_max_bit;
    logic [BIT_W-1:0] w_max_cnt;

    assign w_diff = sample_in ^ r_prev;

    popcount #(
        .WIDTH (WIDTH),
        .CNT_W (POP_W)
    ) u_popcount (
        .i_bits  (w_diff),
        .o_count (w_pop)
    );

    assign w_acc_next    = r_acc + TOG_W'(w_pop);
    assign w_window_done = w_compare && (r_ncmp == BIT_W'(WINDOW - 1));

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_bitcnt_next[i] = r_bitcnt[i] + BIT_W'(w_diff[i]);
        end
    end

    // Scan the counts that already include this cycle's comparison, so the
    // closing comparison is part of the reported result.
    always_comb begin
        w_max_bit = '0;
        w_max_cnt = w_bitcnt_next[0];
        for (int i = 1; i < WIDTH; i++) begin
            if (w_bitcnt_next[i] > w_max_cnt) begin
                w_max_cnt = w_bitcnt_next[i];
                w_max_bit = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_acc  <= '0;
            r_ncmp <= '0;
            for (int i = 0; i < WIDTH; i++) r_bitcnt[i] <= '0;
            if (rst) r_prev <= '0;
        end else if (w_capture) begin
            r_prev <= sample_in;
        end else if (w_compare) begin
            // prev always advances, so the next window starts from the last
            // sample of this one without a re-prime.
            r_prev <= sample_in;
            if (w_window_done) begin
                r_acc  <= '0;
                r_ncmp <= '0;
                for (int i = 0; i < WIDTH; i++) r_bitcnt[i] <= '0;
            end else begin
                r_acc  <= w_acc_next;
                r_ncmp <= r_ncmp + BIT_W'(1);
                for (int i = 0; i < WIDTH; i++) r_bitcnt[i] <= w_bitcnt_next[i];
            end
        end
    end

    // ---------------- Output register ----------------
    logic             r_res_valid;
    logic [TOG_W-1:0] r_res_toggles;
    logic [IDX_W-1:0] r_res_max_bit;
    logic [BIT_W-1:0] r_res_max_cnt;
    logic             r_overrun;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid   <= 1'b0;
            r_res_toggles <= '0;
            r_res_max_bit <= '0;
            r_res_max_cnt <= '0;
            r_overrun     <= 1'b0;
        end else if (w_window_done) begin
            if (!r_res_valid || res_ready) begin
                r_res_valid   <= 1'b1;
                r_res_toggles <= w_acc_next;
                r_res_max_bit <= w_max_bit;
                r_res_max_cnt <= w_max_cnt;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid   = r_res_valid;
    assign res_toggles = r_res_toggles;
    assign res_max_bit = r_res_max_bit;
    assign res_max_cnt = r_res_max_cnt;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_toggle_activity_monitor.sv
module tb_toggle_activity_monitor;
    import power_est_pkg::*;

    localparam int WIDTH  = 4;
    localparam int WINDOW = 16;
    localparam int TOG_W  = 7;
    localparam int BIT_W  = 5;
    localparam int IDX_W  = 2;
    localparam int RES_W  = TOG_W + IDX_W + BIT_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             en;
    logic [WIDTH-1:0] sample_in;
    logic             res_ready;
    logic             res_valid;
    logic [TOG_W-1:0] res_toggles;
    logic [IDX_W-1:0] res_max_bit;
    logic [BIT_W-1:0] res_max_cnt;
    logic             overrun;
    logic [1:0]       dbg_state;

    toggle_activity_monitor #(
        .WIDTH  (WIDTH),
        .WINDOW (WINDOW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .sample_in   (sample_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_toggles (res_toggles),
        .res_max_bit (res_max_bit),
        .res_max_cnt (res_max_cnt),
        .overrun     (overrun),
        .dbg_state   (dbg_state)
    );

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Keeps the raw samples of the current window; a window is complete once
    // it holds WINDOW+1 samples (WINDOW transitions). Toggles are counted from
    // the sample list directly.
    logic [WIDTH-1:0] win_q[$];
    int               run = 0;  // consecutive enabled cycles, saturating at 2
    logic             m_valid = 1'b0;
    logic             m_over  = 1'b0;
    logic [TOG_W-1:0] m_tog   = '0;
    logic [IDX_W-1:0] m_bit   = '0;
    logic [BIT_W-1:0] m_cnt   = '0;

    always @(posedge clk) begin : model
        logic             done;
        int               tog;
        int               cnt [WIDTH];
        int               best;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] last;
        done = 1'b0;
        tog  = 0;
        best = 0;
        for (int i = 0; i < WIDTH; i++) cnt[i] = 0;
        if (rst) begin
            run = 0;
            win_q.delete();
            m_valid = 1'b0;
            m_over  = 1'b0;
            m_tog   = '0;
            m_bit   = '0;
            m_cnt   = '0;
        end else begin
            if (!en) begin
                run = 0;
                win_q.delete();
            end else if (run == 0) begin
                run = 1;
            end else if (run == 1) begin
                win_q.delete();
                win_q.push_back(sample_in);
                run = 2;
            end else begin
                win_q.push_back(sample_in);
                if (win_q.size() == WINDOW + 1) begin
                    for (int j = 1; j <= WINDOW; j++) begin
                        d = win_q[j] ^ win_q[j-1];
                        tog += $countones(d);
                        for (int i = 0; i < WIDTH; i++) cnt[i] += int'(d[i]);
                    end
                    for (int i = 1; i < WIDTH; i++) if (cnt[i] > cnt[best]) best = i;
                    last = win_q[WINDOW];
                    win_q.delete();
                    win_q.push_back(last);
                    done = 1'b1;
                end
            end
            if (done) begin
                if (!m_valid || res_ready) begin
                    m_valid = 1'b1;
                    m_tog   = TOG_W'(tog);
                    m_bit   = IDX_W'(best);
                    m_cnt   = BIT_W'(cnt[best]);
                end else begin
                    m_over = 1'b1;
                end
            end else if (m_valid && res_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        check("res_valid",   32'(res_valid),   32'(m_valid));
        check("overrun",     32'(overrun),     32'(m_over));
        check("res_toggles", 32'(res_toggles), 32'(m_tog));
        check("res_max_bit", 32'(res_max_bit), 32'(m_bit));
        check("res_max_cnt", 32'(res_max_cnt), 32'(m_cnt));
    end

    // Accepted results, for literal expectations per scenario.
    logic [RES_W-1:0] got_q[$];
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) got_q.push_back({res_toggles, res_max_bit, res_max_cnt});
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic e, input logic [WIDTH-1:0] s, input logic r);
        en        = e;
        sample_in = s;
        res_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b1);
    endtask

    task automatic expect_results(input string name, input int n, input int tog, input int bt, input int cnt);
        logic [RES_W-1:0] e;
        check({name, "_count"}, 32'(got_q.size()), 32'(n));
        foreach (got_q[j]) begin
            e = got_q[j];
            check({name, "_tog"}, 32'(e[RES_W-1 -: TOG_W]),      32'(tog));
            check({name, "_bit"}, 32'(e[BIT_W +: IDX_W]),        32'(bt));
            check({name, "_cnt"}, 32'(e[BIT_W-1:0]),             32'(cnt));
        end
        got_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        sample_in = '0;
        res_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_valid",   32'(res_valid),   32'd0);
        check("reset_overrun", 32'(overrun),     32'd0);
        check("reset_toggles", 32'(res_toggles), 32'd0);
        check("reset_state",   32'(dbg_state),   32'(ST_IDLE));
        rst = 1'b0;

        // Counter 0..15,0 twice, back to back.
        drive(1'b1, 4'h0, 1'b1);
        drive(1'b1, 4'h0, 1'b1);
        for (int k = 1; k <= 2 * WINDOW; k++) drive(1'b1, 4'(k % 16), 1'b1);
        idle_cycles(3);
        expect_results("counter", 2, 30, 0, 16);

        // Constant bus.
        drive(1'b1, 4'hA, 1'b1);
        drive(1'b1, 4'hA, 1'b1);
        for (int k = 1; k <= 2 * WINDOW; k++) drive(1'b1, 4'hA, 1'b1);
        idle_cycles(3);
        expect_results("constant", 2, 0, 0, 0);

        // Alternating 0/F: every bit toggles every cycle, all tie.
        drive(1'b1, 4'h0, 1'b1);
        drive(1'b1, 4'h0, 1'b1);
        for (int k = 1; k <= WINDOW; k++) drive(1'b1, (k % 2 == 1) ? 4'hF : 4'h0, 1'b1);
        idle_cycles(3);
        expect_results("alternating", 1, 64, 0, 16);

        // Back-pressure across three windows; ready rises on the third close.
        drive(1'b1, 4'h0, 1'b0);
        drive(1'b1, 4'h0, 1'b0);
        for (int k = 1; k <= 3 * WINDOW; k++) begin
            drive(1'b1, 4'(k % 16), (k == 3 * WINDOW) ? 1'b1 : 1'b0);
            if (k == WINDOW) begin
                check("bp_w1_valid",   32'(res_valid),   32'd1);
                check("bp_w1_toggles", 32'(res_toggles), 32'd30);
                check("bp_w1_overrun", 32'(overrun),     32'd0);
            end
            if (k == 2 * WINDOW) begin
                check("bp_w2_overrun", 32'(overrun),     32'd1);
                check("bp_w2_valid",   32'(res_valid),   32'd1);
            end
        end
        check("bp_w3_valid_no_gap", 32'(res_valid), 32'd1);
        drive(1'b0, 4'h0, 1'b0);
        check("bp_hold_valid", 32'(res_valid), 32'd1);
        idle_cycles(3);
        expect_results("backpressure", 2, 30, 0, 16);

        // en dropped after 7 alternating comparisons; the new window must not
        // include any of them.
        drive(1'b1, 4'h0, 1'b1);
        drive(1'b1, 4'h0, 1'b1);
        for (int k = 1; k <= 7; k++) drive(1'b1, (k % 2 == 1) ? 4'hF : 4'h0, 1'b1);
        drive(1'b0, 4'h0, 1'b1);
        drive(1'b1, 4'h3, 1'b1);
        check("reprime_state", 32'(dbg_state), 32'(ST_PRIME));
        drive(1'b1, 4'h3, 1'b1);
        for (int k = 1; k <= WINDOW; k++) drive(1'b1, 4'((3 + k) % 16), 1'b1);
        idle_cycles(3);
        expect_results("en_drop", 1, 30, 0, 16);

        // Reset mid-window with a result pending (overrun still set).
        drive(1'b1, 4'h0, 1'b0);
        drive(1'b1, 4'h0, 1'b0);
        for (int k = 1; k <= WINDOW + 5; k++) drive(1'b1, 4'(k % 16), 1'b0);
        check("pre_rst_valid", 32'(res_valid), 32'd1);
        rst = 1'b1;
        drive(1'b1, 4'h6, 1'b0);
        check("rst_valid",   32'(res_valid),   32'd0);
        check("rst_overrun", 32'(overrun),     32'd0);
        check("rst_state",   32'(dbg_state),   32'(ST_IDLE));
        check("rst_toggles", 32'(res_toggles), 32'd0);
        check("rst_max_bit", 32'(res_max_bit), 32'd0);
        check("rst_max_cnt", 32'(res_max_cnt), 32'd0);
        rst = 1'b0;

        // One clean window after reset.
        drive(1'b1, 4'h5, 1'b1);
        drive(1'b1, 4'h5, 1'b1);
        for (int k = 1; k <= WINDOW; k++) drive(1'b1, 4'((5 + k) % 16), 1'b1);
        idle_cycles(3);
        expect_results("after_rst", 1, 30, 0, 16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
